// File: rtl/ex_stage_muldiv_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_stage_muldiv_if : ID/EX inputs and EX/MEM outputs of ex_stage_muldiv   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface ex_stage_muldiv_if;
  logic        IDtoEX_valid;
  logic [31:0] IDtoEX_PC4;
  logic [31:0] IDtoEX_ReadData1;
  logic [31:0] IDtoEX_ReadData2;
  logic [31:0] IDtoEX_SignExtImm;
  logic [4:0]  IDtoEX_Rt;
  logic [4:0]  IDtoEX_Rd;
  logic        ALUSrc;
  logic        RegDst;
  logic [3:0]  ALUCtrl;
  logic        Branch;
  logic        MemWrite;
  logic        MemRead;
  logic        RegWrite;
  logic        MemtoReg;
  logic        EX_flush;
  logic        EX_stall;
  logic        EXtoMEM_valid;
  logic        EXtoMEM_zero;
  logic [31:0] EXtoMEM_ALUresult;
  logic [31:0] EXtoMEM_WriteData;
  logic [4:0]  EXtoMEM_Rt;
  logic [31:0] EXtoMEM_Branch_Addr;
  logic [4:0]  EXtoMEM_RegDest;
  logic        EXtoMEM_Branch;
  logic        EXtoMEM_MemWrite;
  logic        EXtoMEM_MemRead;
  logic        EXtoMEM_RegWrite;
  logic        EXtoMEM_MemtoReg;

  modport master (
    output IDtoEX_valid, IDtoEX_PC4, IDtoEX_ReadData1, IDtoEX_ReadData2,
           IDtoEX_SignExtImm, IDtoEX_Rt, IDtoEX_Rd, ALUSrc, RegDst, ALUCtrl,
           Branch, MemWrite, MemRead, RegWrite, MemtoReg, EX_flush,
    input  EX_stall, EXtoMEM_valid, EXtoMEM_zero, EXtoMEM_ALUresult,
           EXtoMEM_WriteData, EXtoMEM_Rt, EXtoMEM_Branch_Addr, EXtoMEM_RegDest,
           EXtoMEM_Branch, EXtoMEM_MemWrite, EXtoMEM_MemRead, EXtoMEM_RegWrite,
           EXtoMEM_MemtoReg
  );

  modport slave (
    input  IDtoEX_valid, IDtoEX_PC4, IDtoEX_ReadData1, IDtoEX_ReadData2,
           IDtoEX_SignExtImm, IDtoEX_Rt, IDtoEX_Rd, ALUSrc, RegDst, ALUCtrl,
           Branch, MemWrite, MemRead, RegWrite, MemtoReg, EX_flush,
    output EX_stall, EXtoMEM_valid, EXtoMEM_zero, EXtoMEM_ALUresult,
           EXtoMEM_WriteData, EXtoMEM_Rt, EXtoMEM_Branch_Addr, EXtoMEM_RegDest,
           EXtoMEM_Branch, EXtoMEM_MemWrite, EXtoMEM_MemRead, EXtoMEM_RegWrite,
           EXtoMEM_MemtoReg
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_stage_muldiv : EX stage + EX/MEM register, optional iterative MUL/DIV  |
// | (enabled by EX_MULDIV_EN).  Rev 1.0                                      |
// +--------------------------------------------------------------------------+
module ex_stage_muldiv (
  input  wire logic         clk,
  input  wire logic         reset_n,
  ex_stage_muldiv_if.slave  bus
);
  logic [31:0] w_a, w_b, w_alu;
  logic        w_stall, w_valid_d;

  assign w_a = bus.IDtoEX_ReadData1;
  assign w_b = bus.ALUSrc ? bus.IDtoEX_SignExtImm : bus.IDtoEX_ReadData2;

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic        divz_q, divz_d, isdiv_q, isdiv_d;

  logic        w_is_mul, w_is_div, w_signed, w_start;
  logic [31:0] w_mag_a, w_mag_b, w_rem_n, w_quo, w_rem;
  logic [32:0] w_sum, w_shl, w_sub;
  logic [63:0] w_prod;
  logic        w_ge;

  assign w_is_mul = (bus.ALUCtrl == 4'b1000) || (bus.ALUCtrl == 4'b1001);
  assign w_is_div = (bus.ALUCtrl == 4'b1010) || (bus.ALUCtrl == 4'b1011);
  assign w_signed = ~bus.ALUCtrl[0];
  assign w_start  = (state_q == S_IDLE) && bus.IDtoEX_valid && (w_is_mul || w_is_div)
                    && !bus.EX_flush;
  assign w_stall  = w_start || (!bus.EX_flush && ((state_q == S_MUL) || (state_q == S_DIV)));

  assign w_mag_a = (w_signed && w_a[31]) ? (32'd0 - w_a) : w_a;
  assign w_mag_b = (w_signed && w_b[31]) ? (32'd0 - w_b) : w_b;

  // acc holds {HI,LO} while multiplying and {remainder,quotient} while dividing
  assign w_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign w_shl   = acc_q[63:31];
  assign w_sub   = w_shl - {1'b0, opb_q};
  assign w_ge    = ~w_sub[32];
  assign w_rem_n = w_ge ? w_sub[31:0] : w_shl[31:0];

  assign w_prod = neg_res_q ? (64'd0 - acc_q) : acc_q;
  assign w_quo  = divz_q ? 32'hFFFF_FFFF : (neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
  assign w_rem  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    isdiv_d   = isdiv_q;
    if (bus.EX_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            acc_d     = {32'd0, (w_is_mul ? w_mag_b : w_mag_a)};
            opb_d     = w_is_mul ? w_mag_a : w_mag_b;
            cnt_d     = 6'd0;
            neg_res_d = w_signed && (w_a[31] ^ w_b[31]);
            neg_rem_d = w_signed && w_a[31];
            divz_d    = (w_b == 32'd0);
            isdiv_d   = w_is_div;
            state_d   = w_is_mul ? S_MUL : S_DIV;
          end
        end
        S_MUL: begin
          acc_d = {w_sum, acc_q[31:1]};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = S_DONE;
        end
        S_DIV: begin
          acc_d = {w_rem_n, acc_q[30:0], w_ge};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = S_DONE;
        end
        S_DONE: begin
          if (isdiv_q) begin
            hi_d = w_rem;
            lo_d = w_quo;
          end else begin
            hi_d = w_prod[63:32];
            lo_d = w_prod[31:0];
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      cnt_q     <= 6'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      isdiv_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      isdiv_q   <= isdiv_d;
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_alu = 32'd0;
    case (bus.ALUCtrl)
      4'b0000: w_alu = w_a & w_b;
      4'b0001: w_alu = w_a | w_b;
      4'b0010: w_alu = w_a + w_b;
      4'b0110: w_alu = w_a - w_b;
      4'b0111: w_alu = {31'd0, ($signed(w_a) < $signed(w_b))};
      4'b1100: w_alu = ~(w_a | w_b);
`ifdef EX_MULDIV_EN
      4'b1101: w_alu = hi_q;
      4'b1110: w_alu = lo_q;
`endif
      default: w_alu = 32'd0;
    endcase
  end

  assign bus.EX_stall = w_stall;
  assign w_valid_d    = bus.IDtoEX_valid && !w_stall && !bus.EX_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.EXtoMEM_valid       <= 1'b0;
      bus.EXtoMEM_zero        <= 1'b0;
      bus.EXtoMEM_ALUresult   <= 32'd0;
      bus.EXtoMEM_WriteData   <= 32'd0;
      bus.EXtoMEM_Rt          <= 5'd0;
      bus.EXtoMEM_Branch_Addr <= 32'd0;
      bus.EXtoMEM_RegDest     <= 5'd0;
      bus.EXtoMEM_Branch      <= 1'b0;
      bus.EXtoMEM_MemWrite    <= 1'b0;
      bus.EXtoMEM_MemRead     <= 1'b0;
      bus.EXtoMEM_RegWrite    <= 1'b0;
      bus.EXtoMEM_MemtoReg    <= 1'b0;
    end else begin
      bus.EXtoMEM_valid       <= w_valid_d;
      bus.EXtoMEM_zero        <= (w_alu == 32'd0);
      bus.EXtoMEM_ALUresult   <= w_alu;
      bus.EXtoMEM_WriteData   <= bus.IDtoEX_ReadData2;
      bus.EXtoMEM_Rt          <= bus.IDtoEX_Rt;
      bus.EXtoMEM_Branch_Addr <= bus.IDtoEX_PC4 + {bus.IDtoEX_SignExtImm[29:0], 2'b00};
      bus.EXtoMEM_RegDest     <= bus.RegDst ? bus.IDtoEX_Rd : bus.IDtoEX_Rt;
      bus.EXtoMEM_Branch      <= w_valid_d && bus.Branch;
      bus.EXtoMEM_MemWrite    <= w_valid_d && bus.MemWrite;
      bus.EXtoMEM_MemRead     <= w_valid_d && bus.MemRead;
      bus.EXtoMEM_RegWrite    <= w_valid_d && bus.RegWrite;
      bus.EXtoMEM_MemtoReg    <= w_valid_d && bus.MemtoReg;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ex_stage_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ex_stage_muldiv : directed self-checking bench for ex_stage_muldiv     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ex_stage_muldiv;
  logic clk;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  ex_stage_muldiv_if bus ();

  ex_stage_muldiv dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.IDtoEX_valid      = 1'b0;
    bus.IDtoEX_PC4        = 32'd0;
    bus.IDtoEX_ReadData1  = 32'd0;
    bus.IDtoEX_ReadData2  = 32'd0;
    bus.IDtoEX_SignExtImm = 32'd0;
    bus.IDtoEX_Rt         = 5'd0;
    bus.IDtoEX_Rd         = 5'd0;
    bus.ALUSrc            = 1'b0;
    bus.RegDst            = 1'b0;
    bus.ALUCtrl           = 4'b0000;
    bus.Branch            = 1'b0;
    bus.MemWrite          = 1'b0;
    bus.MemRead           = 1'b0;
    bus.RegWrite          = 1'b0;
    bus.MemtoReg          = 1'b0;
    bus.EX_flush          = 1'b0;
  endtask

  task automatic op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    clear_in();
    bus.IDtoEX_valid     = 1'b1;
    bus.ALUCtrl          = ctrl;
    bus.IDtoEX_ReadData1 = a;
    bus.IDtoEX_ReadData2 = b;
    bus.RegWrite         = 1'b1;
  endtask

`ifdef EX_MULDIV_EN
  // Runs one MULT/DIV from presentation to its EX/MEM issue, returns stall length
  task automatic run_muldiv(input logic [3:0] ctrl, input logic [31:0] a,
                            input logic [31:0] b, output int stalls, output int bubble_bad);
    op(ctrl, a, b);
    stalls     = 0;
    bubble_bad = 0;
    #1;
    while (bus.EX_stall === 1'b1 && stalls < 40) begin
      stalls++;
      tick();
      if (bus.EXtoMEM_valid !== 1'b0 || bus.EXtoMEM_RegWrite !== 1'b0) bubble_bad++;
    end
    tick();
  endtask

  int stalls, bubble_bad;
`endif

  initial begin
    clear_in();
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_valid",  {31'd0, bus.EXtoMEM_valid}, 32'd0);
    check("rst_alu",    bus.EXtoMEM_ALUresult, 32'd0);
    check("rst_baddr",  bus.EXtoMEM_Branch_Addr, 32'd0);
    check("rst_regwr",  {31'd0, bus.EXtoMEM_RegWrite}, 32'd0);
    check("rst_stall",  {31'd0, bus.EX_stall}, 32'd0);
    reset_n = 1'b1;
    tick();

    op(4'b0010, 32'h7FFF_FFFF, 32'd1);
    bus.RegDst = 1'b1; bus.IDtoEX_Rd = 5'd5; bus.IDtoEX_Rt = 5'd3;
    tick();
    check("add_res",   bus.EXtoMEM_ALUresult, 32'h8000_0000);
    check("add_zero",  {31'd0, bus.EXtoMEM_zero}, 32'd0);
    check("add_valid", {31'd0, bus.EXtoMEM_valid}, 32'd1);
    check("add_regwr", {31'd0, bus.EXtoMEM_RegWrite}, 32'd1);
    check("add_dest",  {27'd0, bus.EXtoMEM_RegDest}, 32'd5);
    check("add_wdata", bus.EXtoMEM_WriteData, 32'd1);
    check("add_rt",    {27'd0, bus.EXtoMEM_Rt}, 32'd3);

    op(4'b0110, 32'd5, 32'd5);
    bus.IDtoEX_Rt = 5'd9;
    tick();
    check("sub_res",  bus.EXtoMEM_ALUresult, 32'd0);
    check("sub_zero", {31'd0, bus.EXtoMEM_zero}, 32'd1);
    check("sub_dest", {27'd0, bus.EXtoMEM_RegDest}, 32'd9);

    op(4'b0110, 32'd3, 32'd3);
    bus.RegWrite = 1'b0; bus.Branch = 1'b1;
    bus.IDtoEX_PC4 = 32'h0040_0010; bus.IDtoEX_SignExtImm = 32'hFFFF_FFFE;
    tick();
    check("br_addr", bus.EXtoMEM_Branch_Addr, 32'h0040_0008);
    check("br_flag", {31'd0, bus.EXtoMEM_Branch}, 32'd1);

    op(4'b0001, 32'h0000_00F0, 32'h0000_1234);
    bus.ALUSrc = 1'b1; bus.IDtoEX_SignExtImm = 32'h0000_000F;
    tick();
    check("or_imm",   bus.EXtoMEM_ALUresult, 32'h0000_00FF);
    check("or_wdata", bus.EXtoMEM_WriteData, 32'h0000_1234);

    op(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0);
    tick();
    check("and_res", bus.EXtoMEM_ALUresult, 32'h0F00_0F00);

    op(4'b0111, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("slt_neg", bus.EXtoMEM_ALUresult, 32'd1);

    op(4'b0111, 32'd1, 32'hFFFF_FFFF);
    tick();
    check("slt_pos", bus.EXtoMEM_ALUresult, 32'd0);

    op(4'b1100, 32'd0, 32'h0000_FFFF);
    tick();
    check("nor_res", bus.EXtoMEM_ALUresult, 32'hFFFF_0000);

    op(4'b0011, 32'd7, 32'd9);
    tick();
    check("undef_res", bus.EXtoMEM_ALUresult, 32'd0);

    op(4'b0010, 32'd1, 32'd1);
    bus.IDtoEX_valid = 1'b0; bus.MemWrite = 1'b1;
    tick();
    check("bub_valid", {31'd0, bus.EXtoMEM_valid}, 32'd0);
    check("bub_ctrl",  {27'd0, bus.EXtoMEM_RegWrite, bus.EXtoMEM_MemWrite, 3'b000}, 32'd0);

    op(4'b0010, 32'd1, 32'd1);
    bus.MemRead = 1'b1; bus.MemtoReg = 1'b1; bus.EX_flush = 1'b1;
    tick();
    check("fl_valid", {31'd0, bus.EXtoMEM_valid}, 32'd0);
    check("fl_ctrl",  {30'd0, bus.EXtoMEM_MemRead, bus.EXtoMEM_MemtoReg}, 32'd0);

`ifdef EX_MULDIV_EN
    run_muldiv(4'b1000, 32'hFFFF_FFFE, 32'd3, stalls, bubble_bad);
    check("mult_stall",  stalls, 32'd33);
    check("mult_bubble", bubble_bad, 32'd0);
    check("mult_valid",  {31'd0, bus.EXtoMEM_valid}, 32'd1);
    check("mult_res",    bus.EXtoMEM_ALUresult, 32'd0);
    op(4'b1110, 32'd0, 32'd0);
    tick();
    check("mult_lo", bus.EXtoMEM_ALUresult, 32'hFFFF_FFFA);
    op(4'b1101, 32'd0, 32'd0);
    tick();
    check("mult_hi", bus.EXtoMEM_ALUresult, 32'hFFFF_FFFF);

    run_muldiv(4'b1010, 32'hFFFF_FFF9, 32'd2, stalls, bubble_bad);
    check("div_stall", stalls, 32'd33);
    op(4'b1110, 32'd0, 32'd0);
    tick();
    check("div_lo", bus.EXtoMEM_ALUresult, 32'hFFFF_FFFD);
    op(4'b1101, 32'd0, 32'd0);
    tick();
    check("div_hi", bus.EXtoMEM_ALUresult, 32'hFFFF_FFFF);

    run_muldiv(4'b1011, 32'd9, 32'd0, stalls, bubble_bad);
    check("divz_stall", stalls, 32'd33);
    op(4'b1110, 32'd0, 32'd0);
    tick();
    check("divz_lo", bus.EXtoMEM_ALUresult, 32'hFFFF_FFFF);
    op(4'b1101, 32'd0, 32'd0);
    tick();
    check("divz_hi", bus.EXtoMEM_ALUresult, 32'd9);

    op(4'b1001, 32'd5, 32'd7);
    tick();
    repeat (10) tick();
    check("mu_stall_on", {31'd0, bus.EX_stall}, 32'd1);
    bus.EX_flush = 1'b1;
    #1;
    check("mu_stall_fl", {31'd0, bus.EX_stall}, 32'd0);
    tick();
    check("mu_fl_valid", {31'd0, bus.EXtoMEM_valid}, 32'd0);
    op(4'b1101, 32'd0, 32'd0);
    #1;
    check("mu_idle", {31'd0, bus.EX_stall}, 32'd0);
    tick();
    check("mu_hi_kept", bus.EXtoMEM_ALUresult, 32'd9);
    op(4'b1110, 32'd0, 32'd0);
    tick();
    check("mu_lo_kept", bus.EXtoMEM_ALUresult, 32'hFFFF_FFFF);

    op(4'b1010, 32'd100, 32'd7);
    bus.IDtoEX_PC4 = 32'h0000_1000;
    tick();
    repeat (5) tick();
    check("rd_baddr_pre", bus.EXtoMEM_Branch_Addr, 32'h0000_1000);
    #2;
    bus.IDtoEX_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rd_stall", {31'd0, bus.EX_stall}, 32'd0);
    check("rd_baddr", bus.EXtoMEM_Branch_Addr, 32'd0);
    check("rd_valid", {31'd0, bus.EXtoMEM_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    op(4'b1110, 32'd0, 32'd0);
    tick();
    check("rd_lo_clr", bus.EXtoMEM_ALUresult, 32'd0);
    check("rd_lo_val", {31'd0, bus.EXtoMEM_valid}, 32'd1);
`else
    op(4'b1000, 32'hFFFF_FFFE, 32'd3);
    #1;
    check("nomd_stall", {31'd0, bus.EX_stall}, 32'd0);
    tick();
    check("nomd_res",   bus.EXtoMEM_ALUresult, 32'd0);
    check("nomd_valid", {31'd0, bus.EXtoMEM_valid}, 32'd1);
    check("nomd_zero",  {31'd0, bus.EXtoMEM_zero}, 32'd1);
    op(4'b1110, 32'd5, 32'd6);
    #1;
    check("nomd_stall2", {31'd0, bus.EX_stall}, 32'd0);
    tick();
    check("nomd_mflo", bus.EXtoMEM_ALUresult, 32'd0);
`endif

    clear_in();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ex_stage_muldiv.md
# ex_stage_muldiv

Execute stage with an integrated EX/MEM pipeline register and an iterative multiply/divide unit. It takes decoded operands and control from the ID/EX boundary and computes ALU results, branch targets and destination registers. It drives the registered `EXtoMEM_*` datapath and control bundle consumed by the MEM stage. Multi-cycle MULT/DIV operations stall upstream through `EX_stall` and write the internal HI/LO registers.

## Interface
Parameters:
- none (width fixed at 32).

Ports:
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `IDtoEX_valid` in 1: the ID/EX slot holds a real instruction.
- `IDtoEX_PC4` in 32: PC+4 of the instruction.
- `IDtoEX_ReadData1` in 32, `IDtoEX_ReadData2` in 32: register operands A and B.
- `IDtoEX_SignExtImm` in 32: sign-extended immediate.
- `IDtoEX_Rt` in 5, `IDtoEX_Rd` in 5: register specifiers.
- `ALUSrc`, `RegDst` in 1 each: B = imm when `ALUSrc`=1; destination = Rd when `RegDst`=1, else Rt.
- `ALUCtrl` in 4: operation code (see Operation).
- `Branch`, `MemWrite`, `MemRead`, `RegWrite`, `MemtoReg` in 1 each: control passed to MEM/WB.
- `EX_flush` in 1: kill the instruction in EX (taken branch from MEM).
- `EX_stall` out 1: upstream must hold the ID/EX contents.
- `EXtoMEM_valid` out 1.
- `EXtoMEM_zero` out 1.
- `EXtoMEM_ALUresult` out 32.
- `EXtoMEM_WriteData` out 32: `IDtoEX_ReadData2`, the store data.
- `EXtoMEM_Rt` out 5.
- `EXtoMEM_Branch_Addr` out 32.
- `EXtoMEM_RegDest` out 5.
- `EXtoMEM_Branch`, `EXtoMEM_MemWrite`, `EXtoMEM_MemRead`, `EXtoMEM_RegWrite`, `EXtoMEM_MemtoReg` out 1 each.

## Operation
ALU operations (`ALUCtrl`):
- 0000 AND, 0001 OR, 0010 ADD (mod 2^32, no overflow trap), 0110 SUB, 0111 SLT (signed, result 0 or 1), 1100 NOR.
- 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU, 1101 MFHI, 1110 MFLO.
- Any other code: result 0.

Datapath results:
- `zero` = (ALU result == 0).
- `Branch_Addr` = PC4 + (SignExtImm << 2), truncated to 32 bits.

State machine (IDLE, MUL, DIV, DONE):
- IDLE: a valid MULT/MULTU in IDLE latches operands and moves to MUL; a valid DIV/DIVU latches operands and moves to DIV. The 6-bit iteration counter is cleared to 0 in both cases.
- MUL: shift-add, one bit per cycle. After 32 iterations, move to DONE.
- DIV: restoring division, one bit per cycle. Signed variants operate on magnitudes, then fix signs: quotient sign = sign(A) XOR sign(B), remainder sign = sign(A). After 32 iterations, move to DONE.
- DONE: commit HI/LO. Multiply: HI/LO = 64-bit product. Divide: LO = quotient, HI = remainder. The instruction is issued into EX/MEM with its own control bits, and the FSM returns to IDLE.
- Divide by zero (signed or unsigned): LO = 0xFFFFFFFF, HI = A, with the same 32-iteration latency.
- MULT/DIV result: `EXtoMEM_ALUresult` = 0.
- MFHI/MFLO: return the current HI/LO, including a value committed in the immediately preceding DONE cycle.

Pipeline register:
- Captures every cycle unless `EX_stall`=1.
- While stalled it captures a bubble: valid=0 and all control outputs 0. Datapath outputs are don't-care.
- Whenever `EXtoMEM_valid`=0, all five control outputs are 0.

Flush:
- `EX_flush`=1 has priority over everything else.
- EX/MEM captures a bubble.
- Any MUL/DIV in progress is aborted: FSM goes to IDLE, HI/LO are unchanged.
- `EX_stall` is forced to 0 in that cycle.

## Timing
- Reset (asynchronous assert, synchronous release): all `EXtoMEM_*` outputs 0, HI=LO=0, FSM in IDLE, `EX_stall`=0.
- Single-cycle operations: result visible on `EXtoMEM_*` one clock after presentation.
- `EX_stall` is combinational. It is 1 when (IDLE and valid MULT/DIV present and not flush) or state ∈ {MUL, DIV}. It is 0 in DONE.
- MULT/DIV sequence:
  - Presented at cycle 0; stall is high in cycles 0..32 (33 cycles).
  - DONE is cycle 33.
  - `EXtoMEM_valid`=1 for the instruction at the edge ending cycle 33.
  - The next instruction is accepted from cycle 34.
- Upstream holds all `IDtoEX_*` inputs stable while `EX_stall`=1; the operand latch uses only the cycle-0 values.
- `IDtoEX_valid`=0: bubble propagates, no FSM start.

## Configuration
- `EX_MULDIV_EN` defined: HI/LO registers, FSM, MULT/MULTU/DIV/DIVU/MFHI/MFLO supported as above.
- `EX_MULDIV_EN` undefined:
  - No FSM, no HI/LO.
  - Codes 1000–1011, 1101 and 1110 give result 0 and are single-cycle.
  - `EX_stall` tied to 0.

## Test plan
- Reset, then ADD A=0x7FFFFFFF B=1 → `ALUresult`=0x80000000, `zero`=0 next cycle. SUB 5-5 → `zero`=1.
- PC4=0x00400010, imm=0xFFFFFFFE, `Branch`=1 → `Branch_Addr`=0x00400008, `EXtoMEM_Branch`=1.
- MULT A=0xFFFFFFFE (-2), B=3 → `EX_stall` high exactly 33 cycles, EX/MEM bubbles, then MFLO=0xFFFFFFFA and MFHI=0xFFFFFFFF.
- DIV A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=9, B=0 → LO=0xFFFFFFFF, HI=9.
- `EX_flush` at iteration 10 of a MULTU → stall drops the same cycle, bubble issued, HI/LO keep their prior values. Separately, `reset_n` low mid-DIV → all outputs 0 asynchronously.
- Build without `EX_MULDIV_EN`: MULT presented → `EX_stall` never asserted, `ALUresult`=0 one cycle later.
